// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the execute stage to a single-beat data-memory bus.
// Accepts one access at a time, formats strobes/store lanes, runs the
// grant/response handshake with a timeout, and returns extended load data.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRw,
  input  logic [3:0]  bhw,
  input  logic        load_unsign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int NUM_LANES = 4;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Access attributes needed after the bus grant to format load data.
  typedef struct packed {
    logic [3:0] bhw;
    logic       unsign;
    logic [1:0] off;
  } acc_t;

  state_t      state;
  acc_t        acc;
  logic [15:0] tcnt;

  // Request decode at accept time.
  logic size_b, size_h, size_w, bad;
  logic [3:0] strb_n;
  logic [NUM_LANES-1:0][7:0] wdata_n;

  assign size_b = (bhw == 4'b0001);
  assign size_h = (bhw == 4'b0011);
  assign size_w = (bhw == 4'b1111);
  assign bad    = ~(size_b | size_h | size_w) | (size_h & addr[0]) |
                  (size_w & (|addr[1:0]));
  assign strb_n = bhw << addr[1:0];

  // Replicate store data so every enabled strobe sees the right byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_n[i] = size_b ? wdata[7:0] :
                        size_h ? wdata[8*(i%2) +: 8] :
                                 wdata[8*i +: 8];
  end

  // Load formatting: shift the addressed bytes down, then extend.
  logic [31:0] sh, ld_fmt;
  assign sh = mem_rdata >> {acc.off, 3'b000};

  // Pick the extended load result for the captured access size.
  always_comb begin
    ld_fmt = mem_rdata;
    case (acc.bhw)
      4'b0001: ld_fmt = {{24{~acc.unsign & sh[7]}}, sh[7:0]};
      4'b0011: ld_fmt = {{16{~acc.unsign & sh[15]}}, sh[15:0]};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // Control FSM; every output is a register updated on the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      acc       <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            acc       <= '{bhw: bhw, unsign: load_unsign, off: addr[1:0]};
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tcnt      <= '0;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= MemRw;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= strb_n;
              mem_wdata <= wdata_n;
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        REQ: begin
          if (mem_gnt || tcnt == TO_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            tcnt      <= '0;
            // A grant on the last allowed cycle still completes normally.
            if (mem_gnt && !mem_we) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= ~mem_gnt;
              rsp_rdata <= '0;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_fmt;
          end else if (tcnt == TO_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomized bench for lsu_mem_if: directed scenarios plus random accesses
// checked against a byte-level reference model of the access rules.
module tb_lsu_mem_if;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, MemRw, load_unsign;
  logic [3:0]  bhw;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  lsu_mem_if #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRw(MemRw), .bhw(bhw), .load_unsign(load_unsign),
    .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int nb(input logic [3:0] b);
    case (b)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_err(input logic [3:0] b, input logic [31:0] a);
    int n = nb(b);
    return (n == 0) || ((int'(a[1:0]) % n) != 0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [3:0] b, input logic [31:0] a);
    int n = nb(b);
    logic [3:0] s = '0;
    for (int j = 0; j < n; j++) s[int'(a[1:0]) + j] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] b, input logic [31:0] wd);
    int n = nb(b);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] b, input bit uns,
                                           input logic [1:0] off, input logic [31:0] w);
    int n = nb(b);
    logic [31:0] v, m;
    if (n == 4) return w;
    v = w >> (8 * int'(off));
    m = (32'd1 << (8 * n)) - 32'd1;
    v = v & m;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // One access starting at the negedge of an IDLE cycle; ends at the negedge
  // of the IDLE cycle following the response.
  task automatic do_txn(input string nm, input bit we, input logic [3:0] b,
                        input bit uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int gd, input int rdl);
    bit granted = 0, got = 0, ok;
    logic [31:0] erd = '0;
    chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; MemRw = we; bhw = b; load_unsign = uns; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 0; addr = $urandom; wdata = $urandom; bhw = 4'($urandom);
    MemRw = 1'($urandom); load_unsign = 1'($urandom);
    if (is_err(b, a)) begin
      chk({nm, ".err_req"}, 32'(mem_req), 32'd0);
      chk({nm, ".err_vld"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".err_flag"}, 32'(rsp_err), 32'd1);
      chk({nm, ".err_rdata"}, rsp_rdata, 32'd0);
    end else begin
      for (int i = 0; i < TO; i++) begin
        chk({nm, ".req"}, 32'(mem_req), 32'd1);
        chk({nm, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({nm, ".we"}, 32'(mem_we), 32'(we));
        chk({nm, ".strb"}, 32'(mem_wstrb), 32'(exp_strb(b, a)));
        if (we) chk({nm, ".wdata"}, mem_wdata, exp_wd(b, wd));
        chk({nm, ".vld_req"}, 32'(rsp_valid), 32'd0);
        if (i == gd) begin mem_gnt = 1; granted = 1; end
        else mem_rvalid = 1'($urandom);
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        if (granted) break;
      end
      ok = granted;
      if (granted && !we) begin
        for (int i = 0; i < TO; i++) begin
          chk({nm, ".wait_req"}, 32'(mem_req), 32'd0);
          chk({nm, ".wait_vld"}, 32'(rsp_valid), 32'd0);
          if (i == rdl) begin mem_rvalid = 1; mem_rdata = rw; got = 1; end
          else mem_rdata = $urandom;
          @(negedge clk);
          mem_rvalid = 0; mem_rdata = $urandom;
          if (got) break;
        end
        ok = got;
        if (got) erd = exp_load(b, uns, a[1:0], rw);
      end
      chk({nm, ".vld"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".err"}, 32'(rsp_err), ok ? 32'd0 : 32'd1);
      chk({nm, ".rdata"}, rsp_rdata, erd);
      chk({nm, ".req_off"}, 32'(mem_req), 32'd0);
    end
    @(negedge clk);
    chk({nm, ".vld_off"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1; req_valid = 0; MemRw = 0; bhw = 0; load_unsign = 0;
    addr = 0; wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.vld", 32'(rsp_valid), 32'd0);
    rst = 0;
    @(negedge clk);

    // Directed scenarios.
    do_txn("sb",    1, 4'b0001, 0, 32'h1003, 32'h000000A5, 0, 0, 0);
    chk("sb.const_wd", exp_wd(4'b0001, 32'hA5), 32'hA5A5A5A5);
    do_txn("lb_s",  0, 4'b0001, 0, 32'h2002, 0, 32'h12F03456, 0, 0);
    do_txn("lb_u",  0, 4'b0001, 1, 32'h2002, 0, 32'h12F03456, 0, 0);
    do_txn("lh_s",  0, 4'b0011, 0, 32'h2002, 0, 32'h8001FFFF, 0, 0);
    do_txn("lw_d3", 0, 4'b1111, 0, 32'h2000, 0, 32'h8001FFFF, 3, 1);
    do_txn("lw_mis",0, 4'b1111, 0, 32'h2001, 0, 0, 0, 0);
    do_txn("bhw7",  0, 4'b0111, 0, 32'h2000, 0, 0, 0, 0);
    do_txn("to_req",1, 4'b1111, 0, 32'h3000, 32'h11223344, 0, 99, 0);
    do_txn("to_wt", 0, 4'b0011, 1, 32'h3002, 0, 32'h5555AAAA, 0, 99);

    // Stray rvalid while idle must not produce a response.
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 0;
    chk("stray.vld", 32'(rsp_valid), 32'd0);
    chk("stray.busy", 32'(busy), 32'd0);
    do_txn("after_stray", 0, 4'b0001, 0, 32'h4001, 0, 32'h00008000, 1, 2);

    // Reset while waiting for load data.
    req_valid = 1; MemRw = 0; bhw = 4'b1111; addr = 32'h2000; load_unsign = 0;
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rstw.busy_pre", 32'(busy), 32'd1);
    rst = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 0;
    chk("rstw.busy", 32'(busy), 32'd0);
    chk("rstw.req", 32'(mem_req), 32'd0);
    chk("rstw.vld", 32'(rsp_valid), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rstw.ready", 32'(req_ready), 32'd1);
    chk("rstw.vld2", 32'(rsp_valid), 32'd0);

    // Random accesses, issued back-to-back.
    for (int t = 0; t < 150; t++) begin
      logic [3:0] b;
      logic [31:0] a;
      int sel = $urandom_range(0, 7);
      int n;
      b = (sel < 3) ? 4'b0001 : (sel < 5) ? 4'b0011 : (sel < 7) ? 4'b1111 : 4'($urandom);
      a = $urandom;
      n = nb(b);
      if (n != 0 && $urandom_range(0, 2) != 0) a[1:0] = 2'(a[1:0] & 2'(~(n - 1)));
      do_txn("rnd", 1'($urandom), b, 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, TO), $urandom_range(0, TO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
